// File: rtl/pic165x_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pic165x_core_if                                         |
// | Brief    : ROM fetch and port B/C pin bundle for pic165x_core      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface pic165x_core_if;
    logic [11:0] instr;
    logic [9:0]  pc;
    logic [7:0]  pb_out;
    logic [7:0]  pb_dir;
    logic [7:0]  pb_in;
    logic [7:0]  pc_out;
    logic [7:0]  pc_dir;
    logic [7:0]  pc_in;

    modport master (
        input  instr, pb_in, pc_in,
        output pc, pb_out, pb_dir, pc_out, pc_dir
    );

    modport slave (
        output instr, pb_in, pc_in,
        input  pc, pb_out, pb_dir, pc_out, pc_dir
    );
endinterface
`default_nettype wire

// File: rtl/pic165x_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pic165x_core                                            |
// | Brief    : Single-cycle PIC16C5x baseline core, two 8-bit ports    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module pic165x_core #(
    parameter logic [9:0] RESET_VECTOR = 10'h3FF
) (
    input  logic           clk,
    input  logic           rst_n,
    pic165x_core_if.master bus
);
    localparam logic [7:0] c_status_wmask = 8'hE7;
    localparam logic [7:0] c_status_rst   = 8'h18;
    localparam logic [7:0] c_option_rst   = 8'h3F;

    logic [9:0] r_pc;
    logic [9:0] r_stack1;
    logic [9:0] r_stack2;
    logic [7:0] r_w;
    logic [7:0] r_status;
    logic [7:0] r_option;
    logic [7:0] r_tmr0;
    logic [7:0] r_prescaler;
    logic [4:0] r_fsr;
    logic [7:0] r_pb_out;
    logic [7:0] r_pb_dir;
    logic [7:0] r_pc_out;
    logic [7:0] r_pc_dir;
    logic       r_skip;
    logic [7:0] r_ram [8:31];

    logic [11:0] w_ins;
    logic [4:0]  w_f;
    logic [4:0]  w_ea;
    logic        w_d;
    logic [7:0]  w_k;
    logic [2:0]  w_bit;
    logic [7:0]  w_fv;
    logic [9:0]  w_pc_inc;
    logic [8:0]  w_add;
    logic [7:0]  w_inc;
    logic [7:0]  w_dec;
    logic [7:0]  w_res;
    logic        w_wr_f;
    logic        w_wr_w;
    logic        w_c_en;
    logic        w_c;
    logic        w_dc_en;
    logic        w_dc;
    logic        w_z_en;
    logic        w_skip_set;
    logic        w_opt_wr;
    logic        w_trisb_wr;
    logic        w_trisc_wr;
    logic        w_goto;
    logic        w_call;
    logic        w_ret;
    logic        w_f_ok;
    logic        w_we_tmr0;
    logic        w_we_pcl;
    logic        w_we_status;
    logic        w_we_fsr;
    logic        w_we_pb;
    logic        w_we_pc;
    logic        w_we_ram;
    logic [7:0]  w_status_flags;
    logic [7:0]  w_status_next;
    logic [7:0]  w_ps_mask;
    logic [7:0]  w_pre_inc;

    // A pending skip turns the fetched word into a NOP.
    assign w_ins    = r_skip ? 12'h000 : bus.instr;
    assign w_f      = w_ins[4:0];
    assign w_d      = w_ins[5];
    assign w_k      = w_ins[7:0];
    assign w_bit    = w_ins[7:5];
    assign w_ea     = (w_f == 5'd0) ? r_fsr : w_f;
    assign w_pc_inc = r_pc + 10'd1;

    always_comb begin
        case (w_ea)
            5'd0:    w_fv = 8'h00;
            5'd1:    w_fv = r_tmr0;
            5'd2:    w_fv = r_pc[7:0];
            5'd3:    w_fv = r_status;
            5'd4:    w_fv = {3'b111, r_fsr};
            5'd5:    w_fv = 8'h00;
            5'd6:    w_fv = (r_pb_dir & bus.pb_in) | (~r_pb_dir & r_pb_out);
            5'd7:    w_fv = (r_pc_dir & bus.pc_in) | (~r_pc_dir & r_pc_out);
            default: w_fv = r_ram[w_ea];
        endcase
    end

    assign w_add = {1'b0, w_fv} + {1'b0, r_w};
    assign w_inc = w_fv + 8'd1;
    assign w_dec = w_fv - 8'd1;

    always_comb begin
        w_res      = 8'h00;
        w_wr_f     = 1'b0;
        w_wr_w     = 1'b0;
        w_c_en     = 1'b0;
        w_c        = 1'b0;
        w_dc_en    = 1'b0;
        w_dc       = 1'b0;
        w_z_en     = 1'b0;
        w_skip_set = 1'b0;
        w_opt_wr   = 1'b0;
        w_trisb_wr = 1'b0;
        w_trisc_wr = 1'b0;
        w_goto     = 1'b0;
        w_call     = 1'b0;
        w_ret      = 1'b0;
        if (w_ins[11:6] == 6'b000000) begin
            if (w_d) begin
                w_res  = r_w;
                w_wr_f = 1'b1;
            end else if (w_f == 5'd2) begin
                w_opt_wr = 1'b1;
            end else if (w_f == 5'd6) begin
                w_trisb_wr = 1'b1;
            end else if (w_f == 5'd7) begin
                w_trisc_wr = 1'b1;
            end
        end else if (w_ins[11:6] == 6'b000001) begin
            w_res  = 8'h00;
            w_z_en = 1'b1;
            w_wr_f = w_d;
            w_wr_w = ~w_d;
        end else if (w_ins[11:10] == 2'b00) begin
            w_wr_f = w_d;
            w_wr_w = ~w_d;
            case (w_ins[9:6])
                4'h2: begin
                    w_res   = w_fv - r_w;
                    w_c_en  = 1'b1;
                    w_c     = (w_fv >= r_w);
                    w_dc_en = 1'b1;
                    w_dc    = (w_fv[3:0] >= r_w[3:0]);
                    w_z_en  = 1'b1;
                end
                4'h3: begin w_res = w_dec;         w_z_en = 1'b1; end
                4'h4: begin w_res = w_fv | r_w;    w_z_en = 1'b1; end
                4'h5: begin w_res = w_fv & r_w;    w_z_en = 1'b1; end
                4'h6: begin w_res = w_fv ^ r_w;    w_z_en = 1'b1; end
                4'h7: begin
                    w_res   = w_add[7:0];
                    w_c_en  = 1'b1;
                    w_c     = w_add[8];
                    w_dc_en = 1'b1;
                    w_dc    = ({1'b0, w_fv[3:0]} + {1'b0, r_w[3:0]}) > 5'd15;
                    w_z_en  = 1'b1;
                end
                4'h8: begin w_res = w_fv;          w_z_en = 1'b1; end
                4'h9: begin w_res = ~w_fv;         w_z_en = 1'b1; end
                4'hA: begin w_res = w_inc;         w_z_en = 1'b1; end
                4'hB: begin w_res = w_dec; w_skip_set = (w_dec == 8'h00); end
                4'hC: begin
                    w_res  = {r_status[0], w_fv[7:1]};
                    w_c_en = 1'b1;
                    w_c    = w_fv[0];
                end
                4'hD: begin
                    w_res  = {w_fv[6:0], r_status[0]};
                    w_c_en = 1'b1;
                    w_c    = w_fv[7];
                end
                4'hE: w_res = {w_fv[3:0], w_fv[7:4]};
                4'hF: begin w_res = w_inc; w_skip_set = (w_inc == 8'h00); end
                default: begin
                    w_wr_f = 1'b0;
                    w_wr_w = 1'b0;
                end
            endcase
        end else if (w_ins[11:10] == 2'b01) begin
            case (w_ins[9:8])
                2'b00: begin w_res = w_fv & ~(8'd1 << w_bit); w_wr_f = 1'b1; end
                2'b01: begin w_res = w_fv | (8'd1 << w_bit);  w_wr_f = 1'b1; end
                2'b10: w_skip_set = ~w_fv[w_bit];
                default: w_skip_set = w_fv[w_bit];
            endcase
        end else if (w_ins[11:8] == 4'b1000) begin
            w_res  = w_k;
            w_wr_w = 1'b1;
            w_ret  = 1'b1;
        end else if (w_ins[11:8] == 4'b1001) begin
            w_call = 1'b1;
        end else if (w_ins[11:9] == 3'b101) begin
            w_goto = 1'b1;
        end else begin
            w_wr_w = 1'b1;
            w_z_en = (w_ins[9:8] != 2'b00);
            case (w_ins[9:8])
                2'b00:   w_res = w_k;
                2'b01:   w_res = r_w | w_k;
                2'b10:   w_res = r_w & w_k;
                default: w_res = r_w ^ w_k;
            endcase
        end
    end

    // Indirect access through FSR=0 lands on the null register and is dropped.
    assign w_f_ok      = w_wr_f && (w_ea != 5'd0);
    assign w_we_tmr0   = w_f_ok && (w_ea == 5'd1);
    assign w_we_pcl    = w_f_ok && (w_ea == 5'd2);
    assign w_we_status = w_f_ok && (w_ea == 5'd3);
    assign w_we_fsr    = w_f_ok && (w_ea == 5'd4);
    assign w_we_pb     = w_f_ok && (w_ea == 5'd6);
    assign w_we_pc     = w_f_ok && (w_ea == 5'd7);
    assign w_we_ram    = w_f_ok && (w_ea >= 5'd8);

    always_comb begin
        w_status_flags = r_status;
        if (w_c_en) begin
            w_status_flags[0] = w_c;
        end
        if (w_dc_en) begin
            w_status_flags[1] = w_dc;
        end
        if (w_z_en) begin
            w_status_flags[2] = (w_res == 8'h00);
        end
        w_status_next = w_we_status
                      ? ((w_status_flags & ~c_status_wmask) | (w_res & c_status_wmask))
                      : w_status_flags;
    end

    // Low PS+1 bits of the prescaler all zero marks a rollover.
    assign w_ps_mask = 8'hFF >> (3'd7 - r_option[2:0]);
    assign w_pre_inc = r_prescaler + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_stack1    <= 10'd0;
            r_stack2    <= 10'd0;
            r_w         <= 8'h00;
            r_status    <= c_status_rst;
            r_option    <= c_option_rst;
            r_tmr0      <= 8'h00;
            r_prescaler <= 8'h00;
            r_fsr       <= 5'd0;
            r_pb_out    <= 8'h00;
            r_pb_dir    <= 8'hFF;
            r_pc_out    <= 8'h00;
            r_pc_dir    <= 8'hFF;
            r_skip      <= 1'b0;
        end else begin
            r_skip <= w_skip_set;
            if (w_goto) begin
                r_pc <= {r_status[5], w_ins[8:0]};
            end else if (w_call) begin
                r_stack2 <= r_stack1;
                r_stack1 <= w_pc_inc;
                r_pc     <= {r_status[5], 1'b0, w_k};
            end else if (w_ret) begin
                r_pc     <= r_stack1;
                r_stack1 <= r_stack2;
            end else if (w_we_pcl) begin
                r_pc <= {r_status[5], 1'b0, w_res};
            end else begin
                r_pc <= w_pc_inc;
            end
            if (w_wr_w) begin
                r_w <= w_res;
            end
            r_status <= w_status_next;
            if (w_opt_wr) begin
                r_option <= r_w;
            end
            if (w_trisb_wr) begin
                r_pb_dir <= r_w;
            end
            if (w_trisc_wr) begin
                r_pc_dir <= r_w;
            end
            if (w_we_fsr) begin
                r_fsr <= w_res[4:0];
            end
            if (w_we_pb) begin
                r_pb_out <= w_res;
            end
            if (w_we_pc) begin
                r_pc_out <= w_res;
            end
            if (w_we_tmr0) begin
                r_tmr0      <= w_res;
                r_prescaler <= 8'h00;
            end else if (!r_option[5]) begin
                if (r_option[3]) begin
                    r_tmr0 <= r_tmr0 + 8'd1;
                end else begin
                    r_prescaler <= w_pre_inc;
                    if ((w_pre_inc & w_ps_mask) == 8'h00) begin
                        r_tmr0 <= r_tmr0 + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we_ram) begin
            r_ram[w_ea] <= w_res;
        end
    end

    assign bus.pc     = r_pc;
    assign bus.pb_out = r_pb_out;
    assign bus.pb_dir = r_pb_dir;
    assign bus.pc_out = r_pc_out;
    assign bus.pc_dir = r_pc_dir;
endmodule
`default_nettype wire

// File: tb/tb_pic165x_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_pic165x_core                                         |
// | Brief    : Directed + random-ROM bench with an ISA-level model     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_pic165x_core;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [11:0] rom [0:1023];
    int n_checks = 0;
    int n_errors = 0;

    pic165x_core_if bus ();
    assign bus.instr = rom[bus.pc];

    pic165x_core #(.RESET_VECTOR(10'h3FF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Architectural state of the reference machine.
    int m_pc, m_w, m_status, m_fsr, m_option, m_tmr0, m_pre;
    int m_pbo, m_pbd, m_pco, m_pcd, m_s1, m_s2, m_npc;
    bit m_skip, m_tmr_wr;
    int m_ram [0:31];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pin_mix(input int dir, input int pin, input int lat);
        return ((dir & pin) | (~dir & lat)) & 255;
    endfunction

    function automatic int m_read(input int a);
        case (a)
            0, 5:    return 0;
            1:       return m_tmr0;
            2:       return m_pc & 255;
            3:       return m_status;
            4:       return 'hE0 | m_fsr;
            6:       return pin_mix(m_pbd, int'(bus.pb_in), m_pbo);
            7:       return pin_mix(m_pcd, int'(bus.pc_in), m_pco);
            default: return m_ram[a];
        endcase
    endfunction

    task automatic m_write(input int a, input int v);
        v = v & 255;
        case (a)
            0, 5: ;
            1: begin m_tmr0 = v; m_tmr_wr = 1; end
            2: m_npc = ((m_status >> 5) & 1) * 512 + v;
            3: m_status = (m_status & 'h18) | (v & 'hE7);
            4: m_fsr = v & 31;
            6: m_pbo = v;
            7: m_pco = v;
            default: m_ram[a] = v;
        endcase
    endtask

    task automatic set_flag(input int pos, input bit v);
        if (v) m_status = m_status | (1 << pos);
        else   m_status = m_status & ~(1 << pos) & 255;
    endtask

    task automatic model_step(input bit rst);
        int ins, f, a, d, k, b, fv, r, op, opt, cin, pa;
        bit skip;
        if (rst) begin
            m_pc = 'h3FF; m_w = 0; m_status = 'h18; m_fsr = 0; m_option = 'h3F;
            m_tmr0 = 0; m_pre = 0; m_pbo = 0; m_pco = 0; m_pbd = 'hFF; m_pcd = 'hFF;
            m_s1 = 0; m_s2 = 0; m_skip = 0;
            return;
        end
        ins = m_skip ? 0 : int'(rom[m_pc]);
        opt = m_option; skip = 0; m_tmr_wr = 0;
        m_npc = (m_pc + 1) % 1024;
        f = ins & 31; a = (f == 0) ? m_fsr : f; d = (ins >> 5) & 1;
        k = ins & 255; b = (ins >> 5) & 7; op = ins >> 6;
        fv = m_read(a); cin = m_status & 1; pa = (m_status >> 5) & 1;
        if (ins >= 'hA00 && ins < 'hC00) begin
            m_npc = pa * 512 + (ins & 511);
        end else if (ins >= 'h900 && ins < 'hA00) begin
            m_s2 = m_s1; m_s1 = m_npc; m_npc = pa * 512 + k;
        end else if (ins >= 'h800 && ins < 'h900) begin
            m_w = k; m_npc = m_s1; m_s1 = m_s2;
        end else if (ins >= 'hC00) begin
            case ((ins >> 8) & 3)
                0: m_w = k;
                1: m_w = m_w | k;
                2: m_w = m_w & k;
                3: m_w = m_w ^ k;
            endcase
            if (((ins >> 8) & 3) != 0) set_flag(2, m_w == 0);
        end else if (ins >= 'h400) begin
            case ((ins >> 8) & 3)
                0: m_write(a, fv & ~(1 << b));
                1: m_write(a, fv | (1 << b));
                2: skip = ((fv >> b) & 1) == 0;
                3: skip = ((fv >> b) & 1) == 1;
            endcase
        end else if (op == 0) begin
            if (d != 0)      m_write(a, m_w);
            else if (f == 2) m_option = m_w;
            else if (f == 6) m_pbd = m_w;
            else if (f == 7) m_pcd = m_w;
        end else begin
            r = 0;
            case (op)
                2:  begin r = fv - m_w; set_flag(0, fv >= m_w); set_flag(1, (fv & 15) >= (m_w & 15)); end
                3:  r = fv - 1;
                4:  r = fv | m_w;
                5:  r = fv & m_w;
                6:  r = fv ^ m_w;
                7:  begin r = fv + m_w; set_flag(0, r > 255); set_flag(1, (fv & 15) + (m_w & 15) > 15); end
                8:  r = fv;
                9:  r = ~fv;
                10: r = fv + 1;
                11: begin r = fv - 1; skip = (r & 255) == 0; end
                12: begin r = (fv >> 1) | (cin << 7); set_flag(0, (fv & 1) == 1); end
                13: begin r = (fv << 1) | cin; set_flag(0, fv >= 128); end
                14: r = ((fv << 4) | (fv >> 4));
                15: begin r = fv + 1; skip = (r & 255) == 0; end
                default: r = 0;
            endcase
            r = r & 255;
            if (op <= 10) set_flag(2, r == 0);
            if (d != 0) m_write(a, r);
            else        m_w = r;
        end
        m_pc = m_npc;
        m_skip = skip;
        if (m_tmr_wr) begin
            m_pre = 0;
        end else if (((opt >> 5) & 1) == 0) begin
            if (((opt >> 3) & 1) == 1) begin
                m_tmr0 = (m_tmr0 + 1) & 255;
            end else begin
                m_pre = (m_pre + 1) % 256;
                if (m_pre % (2 << (opt & 7)) == 0) m_tmr0 = (m_tmr0 + 1) & 255;
            end
        end
    endtask

    task automatic step_cycle(input bit rst_val, input bit rand_pins);
        rst_n = !rst_val;
        if (rand_pins) begin
            bus.pb_in = 8'($urandom);
            bus.pc_in = 8'($urandom);
        end
        @(posedge clk);
        model_step(rst_val);
        #1;
        check("pc", int'(bus.pc), m_pc);
        check("pb_out", int'(bus.pb_out), m_pbo);
        check("pb_dir", int'(bus.pb_dir), m_pbd);
        check("pc_out", int'(bus.pc_out), m_pco);
        check("pc_dir", int'(bus.pc_dir), m_pcd);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0);
    endtask

    task automatic load_directed();
        for (int i = 0; i < 1024; i++) rom[i] = 12'h000;
        rom['h3FF] = 12'hA00;
        rom[0]  = 12'hC0F; rom[1]  = 12'h007; rom[2]  = 12'hCA5; rom[3]  = 12'h027;
        rom[4]  = 12'h207; rom[5]  = 12'h026;
        rom[6]  = 12'hC80; rom[7]  = 12'h030; rom[8]  = 12'hC80; rom[9]  = 12'h1F0;
        rom[10] = 12'h203; rom[11] = 12'h026; rom[12] = 12'h210; rom[13] = 12'h026;
        rom[14] = 12'hC22; rom[15] = 12'h707; rom[16] = 12'hC11; rom[17] = 12'h026;
        rom[18] = 12'h707; rom[19] = 12'hC33; rom[20] = 12'h026;
        rom[21] = 12'h940; rom[22] = 12'h026;
        rom['h40] = 12'h950; rom['h41] = 12'h8B2; rom['h50] = 12'h8C3;
        rom[23] = 12'hC12; rom[24] = 12'h024; rom[25] = 12'hC3C; rom[26] = 12'h020;
        rom[27] = 12'h212; rom[28] = 12'h026;
        rom[29] = 12'hC01; rom[30] = 12'h033; rom[31] = 12'hC44; rom[32] = 12'h2F3;
        rom[33] = 12'hC55; rom[34] = 12'h026; rom[35] = 12'h213; rom[36] = 12'h006;
        rom[37] = 12'h960;
        rom['h60] = 12'h970; rom['h61] = 12'h8F6; rom['h70] = 12'h980;
        rom['h71] = 12'h8E5; rom['h80] = 12'h8D4;
    endtask

    task automatic load_random();
        for (int i = 0; i < 24; i++) rom[i] = 12'h068 + 12'(i);
        for (int i = 24; i < 1023; i++) begin
            int sel;
            sel = $urandom_range(0, 15);
            case (sel)
                0:       rom[i] = 12'h002;
                1:       rom[i] = 12'h006 + 12'($urandom_range(0, 1));
                2, 3:    rom[i] = {7'($urandom), 5'($urandom_range(0, 7))};
                default: rom[i] = 12'($urandom);
            endcase
        end
        rom['h3FF] = 12'hA00;
    endtask

    initial begin
        bus.pb_in = 8'h00;
        bus.pc_in = 8'h01;
        load_directed();
        step_cycle(1'b1, 1'b0);
        step_cycle(1'b1, 1'b0);
        check("rst_pc", int'(bus.pc), 'h3FF);
        check("rst_pb_dir", int'(bus.pb_dir), 'hFF);
        check("rst_pc_dir", int'(bus.pc_dir), 'hFF);
        check("rst_pb_out", int'(bus.pb_out), 0);
        check("rst_pc_out", int'(bus.pc_out), 0);

        step_cycle(1'b0, 1'b0);
        check("goto_from_vector", int'(bus.pc), 0);
        run(4);
        check("tris_c", int'(bus.pc_dir), 'h0F);
        check("latch_c", int'(bus.pc_out), 'hA5);
        run(2);
        check("port_c_read", int'(bus.pb_out), 'hA1);
        run(6);
        check("addwf_status", int'(bus.pb_out), 'h1D);
        run(2);
        check("addwf_result", int'(bus.pb_out), 'h00);
        run(4);
        check("btfss_taken", int'(bus.pb_out), 'h22);
        check("btfss_taken_pc", int'(bus.pc), 18);
        bus.pc_in = 8'h00;
        run(3);
        check("btfss_not_taken", int'(bus.pb_out), 'h33);
        run(5);
        check("call_retlw_w", int'(bus.pb_out), 'hB2);
        check("call_return_pc", int'(bus.pc), 23);
        run(6);
        check("indf_write", int'(bus.pb_out), 'h3C);
        run(6);
        check("decfsz_skip", int'(bus.pb_out), 'h44);
        check("decfsz_pc", int'(bus.pc), 35);
        run(2);
        check("decfsz_result", int'(bus.pb_dir), 'h00);
        run(6);
        check("stack_overflow_pc", int'(bus.pc), 'h61);
        run(1);
        check("stack_repeat_pc", int'(bus.pc), 'h61);

        load_random();
        step_cycle(1'b1, 1'b1);
        step_cycle(1'b1, 1'b1);
        for (int i = 0; i < 6000; i++) begin
            step_cycle($urandom_range(0, 499) == 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
